// File: rtl/tdes_round_controller.sv
// Triple-DES round sequencer: accepts one block, steps the round datapath
// through three 16-round DES passes (E-D-E or D-E-D), then hands the result
// off with a valid/ready handshake.
module tdes_round_controller #(
  parameter int NUM_ROUNDS = 16,
  parameter int NUM_PASSES = 3,
  localparam int RW = $clog2(NUM_ROUNDS)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mode,
  input  logic          abort,
  output logic          load_block,
  output logic          round_en,
  output logic          pass_end,
  output logic [1:0]    key_sel,
  output logic [RW-1:0] subkey_idx,
  output logic [RW-1:0] round_idx,
  output logic [1:0]    pass_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, PEND, OUTV} state_t;

  state_t        state, state_n;
  logic [RW-1:0] round_cnt, round_n;
  logic [1:0]    pass_cnt, pass_n;
  logic          mode_q, mode_n;
  logic [1:0]    key_sel_q;
  logic [RW-1:0] subkey_q;

  // Encrypt walks K1,K2,K3; decrypt walks K3,K2,K1.
  function automatic logic [1:0] key_of(input logic m, input logic [1:0] pass);
    key_of = m ? (2'd2 - pass) : pass;
  endfunction

  // Middle pass runs opposite to the outer passes; a reverse pass reads
  // the subkey schedule back to front.
  function automatic logic [RW-1:0] subkey_of(input logic m, input logic [1:0] pass,
                                              input logic [RW-1:0] rnd);
    logic fwd;
    fwd = (pass == 2'd1) ? m : !m;
    subkey_of = fwd ? rnd : (RW'(NUM_ROUNDS - 1) - rnd);
  endfunction

  // Next-state and counter update; abort from any busy state wins over all.
  always_comb begin
    state_n = state;
    round_n = round_cnt;
    pass_n  = pass_cnt;
    mode_n  = mode_q;
    case (state)
      IDLE: begin
        if (in_valid && !abort) begin
          mode_n  = mode;
          pass_n  = '0;
          round_n = '0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        round_n = '0;
        state_n = ROUND;
      end
      ROUND: begin
        if (round_cnt == RW'(NUM_ROUNDS - 1)) begin
          round_n = '0;
          state_n = PEND;
        end else begin
          round_n = round_cnt + 1'b1;
        end
      end
      PEND: begin
        if (pass_cnt == 2'(NUM_PASSES - 1)) begin
          state_n = OUTV;
        end else begin
          pass_n  = pass_cnt + 1'b1;
          state_n = LOAD;
        end
      end
      OUTV: begin
        if (out_ready) begin
          pass_n  = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_n = IDLE;
      round_n = '0;
      pass_n  = '0;
    end
  end

  // State, counters and the held key/subkey selection for the coming round.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state     <= IDLE;
      round_cnt <= '0;
      pass_cnt  <= '0;
      mode_q    <= 1'b0;
      key_sel_q <= '0;
      subkey_q  <= '0;
    end else begin
      state     <= state_n;
      round_cnt <= round_n;
      pass_cnt  <= pass_n;
      mode_q    <= mode_n;
      if (state_n == ROUND) begin
        key_sel_q <= key_of(mode_n, pass_n);
        subkey_q  <= subkey_of(mode_n, pass_n, round_n);
      end
    end
  end

  // Output decode from registered state and counters.
  always_comb begin
    in_ready   = (state == IDLE);
    load_block = (state == LOAD);
    round_en   = (state == ROUND);
    pass_end   = (state == PEND);
    out_valid  = (state == OUTV);
    busy       = (state != IDLE);
    done       = (state == OUTV) && out_ready && !abort && !n_rst;
    key_sel    = key_sel_q;
    subkey_idx = subkey_q;
    round_idx  = round_cnt;
    pass_idx   = pass_cnt;
  end

endmodule

// File: tb/tb_tdes_round_controller.sv
// Directed bench for tdes_round_controller with a round-by-round scoreboard
// of expected key bank / subkey pairs.
module tb_tdes_round_controller;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       mode = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, load_block, round_en, pass_end, out_valid, busy, done;
  logic [1:0] key_sel, pass_idx;
  logic [3:0] subkey_idx, round_idx;

  int checks = 0;
  int errors = 0;
  int n_round = 0, n_pend = 0, n_done = 0, n_ov = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  tdes_round_controller #(.NUM_ROUNDS(16), .NUM_PASSES(3)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .abort(abort), .load_block(load_block), .round_en(round_en),
    .pass_end(pass_end), .key_sel(key_sel), .subkey_idx(subkey_idx),
    .round_idx(round_idx), .pass_idx(pass_idx), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {key_sel, subkey_idx} for all 48 rounds of one block.
  task automatic push_block(input logic m);
    for (int p = 0; p < 3; p++) begin
      for (int r = 0; r < 16; r++) begin
        logic [1:0] k;
        logic [3:0] s;
        bit fwd;
        k   = m ? 2'(2 - p) : 2'(p);
        fwd = (m == 1'b0) ? (p != 1) : (p == 1);
        s   = fwd ? 4'(r) : 4'(15 - r);
        exp_q.push_back({k, s});
      end
    end
  endtask

  // Monitor: strobe exclusivity every cycle, scoreboard pop on each round.
  always @(negedge clk) begin
    logic [5:0] exp_e;
    check("strobe_excl", 32'($countones({load_block, round_en, pass_end}) <= 1), 32'd1);
    if (round_en) begin
      n_round++;
      check("round_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("key_subkey", 32'({key_sel, subkey_idx}), 32'(exp_e));
      end
    end
    if (pass_end) n_pend++;
    if (done) n_done++;
    if (out_valid) n_ov++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic m, output time t);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    mode = m;
    push_block(m);
    @(posedge clk);
    t = $time;
    #1;
    in_valid = 1'b0;
    check("load_after_accept", 32'(load_block), 32'd1);
  endtask

  task automatic wait_out(output int e);
    e = 0;
    while (!out_valid && e < 200) begin
      tick();
      e++;
    end
  endtask

  task automatic wait_round(input logic [1:0] p, input logic [3:0] r);
    int n;
    n = 0;
    while (!(round_en && pass_idx == p && round_idx == r) && n < 200) begin
      tick();
      n++;
    end
    check("reach_round", 32'(round_en && pass_idx == p && round_idx == r), 32'd1);
  endtask

  initial begin
    time t0, t1, t2;
    int e, r0, p0, d0, v0;

    // Reset values
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_strobes", 32'({load_block, round_en, pass_end, out_valid, done}), 32'd0);
    check("rst_key", 32'({key_sel, subkey_idx}), 32'd0);
    check("rst_cnt", 32'({round_idx, pass_idx}), 32'd0);
    n_rst = 1'b0;
    tick();

    // Encrypt with late out_ready
    r0 = n_round; p0 = n_pend; d0 = n_done;
    send(1'b0, t0);
    wait_out(e);
    check("enc_latency", 32'(e), 32'd54);
    out_ready = 1'b1;
    @(negedge clk);
    check("enc_done_pulse", 32'(done), 32'd1);
    tick();
    out_ready = 1'b0;
    check("enc_after", 32'({done, out_valid, busy}), 32'd0);
    check("enc_rounds", 32'(n_round - r0), 32'd48);
    check("enc_pends", 32'(n_pend - p0), 32'd3);
    check("enc_dones", 32'(n_done - d0), 32'd1);
    check("enc_q_empty", 32'(exp_q.size()), 32'd0);

    // Decrypt with out_ready already high
    out_ready = 1'b1;
    r0 = n_round; p0 = n_pend; d0 = n_done;
    send(1'b1, t0);
    wait_out(e);
    check("dec_latency", 32'(e), 32'd54);
    tick();
    out_ready = 1'b0;
    check("dec_idle", 32'(busy), 32'd0);
    check("dec_rounds", 32'(n_round - r0), 32'd48);
    check("dec_pends", 32'(n_pend - p0), 32'd3);
    check("dec_dones", 32'(n_done - d0), 32'd1);
    check("dec_q_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure on the result, with ignored in_valid pulses
    d0 = n_done;
    send(1'b0, t0);
    wait_out(e);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      @(negedge clk);
      check("bp_hold", 32'({out_valid, busy, in_ready, done}), 32'b1100);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_done", 32'(done), 32'd1);
    tick();
    out_ready = 1'b0;
    check("bp_idle", 32'({busy, in_ready}), 32'b01);
    tick();
    check("bp_no_stray_load", 32'(load_block), 32'd0);
    check("bp_dones", 32'(n_done - d0), 32'd1);
    check("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // Abort while idle blocks acceptance
    in_valid = 1'b1;
    abort = 1'b1;
    tick();
    in_valid = 1'b0;
    abort = 1'b0;
    check("abort_idle", 32'({load_block, busy}), 32'd0);
    tick();

    // Abort at pass 1, round 7, then a fresh block
    d0 = n_done; v0 = n_ov;
    send(1'b0, t0);
    wait_round(2'd1, 4'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check("abort_state", 32'({busy, out_valid, done, in_ready}), 32'b0001);
    check("abort_cnt", 32'({round_idx, pass_idx}), 32'd0);
    repeat (60) tick();
    check("abort_no_ov", 32'(n_ov - v0), 32'd0);
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    out_ready = 1'b1;
    send(1'b1, t0);
    wait_out(e);
    check("post_abort_latency", 32'(e), 32'd54);
    tick();
    out_ready = 1'b0;
    check("post_abort_dones", 32'(n_done - d0), 32'd1);
    check("post_abort_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset together with abort mid-ROUND; takes effect only at the edge
    d0 = n_done;
    send(1'b0, t0);
    wait_round(2'd0, 4'd5);
    n_rst = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check("rst_sync_wait", 32'({busy, round_en}), 32'b11);
    tick();
    exp_q.delete();
    check("midrst_outs", 32'({busy, load_block, round_en, pass_end, out_valid, done}), 32'd0);
    check("midrst_vals", 32'({key_sel, subkey_idx, round_idx, pass_idx}), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    n_rst = 1'b0;
    abort = 1'b0;
    tick();
    check("midrst_no_done", 32'(n_done - d0), 32'd0);

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    r0 = n_round; p0 = n_pend; d0 = n_done;
    send(1'b0, t0);
    in_valid = 1'b1;
    send(1'b0, t1);
    in_valid = 1'b1;
    send(1'b0, t2);
    wait_out(e);
    tick();
    out_ready = 1'b0;
    check("b2b_space1", 32'((t1 - t0) / 10), 32'd56);
    check("b2b_space2", 32'((t2 - t1) / 10), 32'd56);
    check("b2b_dones", 32'(n_done - d0), 32'd3);
    check("b2b_rounds", 32'(n_round - r0), 32'd144);
    check("b2b_pends", 32'(n_pend - p0), 32'd9);
    check("b2b_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tdes_round_controller.md
Name: tdes_round_controller

Overview:
Sequencer for the Triple-DES core behind the I2C slave interface. Accepts one 64-bit block request by valid/ready handshake and runs three 16-round DES passes (E-D-E for encrypt, D-E-D for decrypt). Drives the round datapath's load/enable strobes, key bank select and subkey index. Presents the result by valid/ready handshake. Uses internal round and pass counters with rollover, in the style of the team's flex counter.

Parameters:
NUM_ROUNDS, 16, rounds per DES pass; round counter width is clog2(NUM_ROUNDS).
NUM_PASSES, 3, DES passes per block; pass counter is 2 bits.

Ports:
clk  in  1  system clock, all logic rising-edge
n_rst  in  1  reset, synchronous and active-high (1 = reset)
in_valid  in  1  input block available from I2C receive side
in_ready  out  1  controller can accept a block
mode  in  1  sampled on accept: 0 = encrypt, 1 = decrypt
abort  in  1  synchronous cancel of the current operation
load_block  out  1  datapath loads its round register (initial perm on pass 0, pass feedback otherwise)
round_en  out  1  datapath performs one round this cycle
pass_end  out  1  datapath applies final permutation/swap for the current pass
key_sel  out  2  key bank: 0 = K1, 1 = K2, 2 = K3 (3 never driven)
subkey_idx  out  4  subkey number for this round (0..15)
round_idx  out  4  current round count
pass_idx  out  2  current pass count
out_valid  out  1  result block valid to I2C transmit side
out_ready  in  1  transmit side accepts result
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on result handshake

Behaviour:
- States: IDLE, LOAD, ROUND, PEND, OUTV. Registered Moore outputs, decoded from state and counters.
- Reset (n_rst=1 at a clk edge): state = IDLE, round_cnt = 0, pass_cnt = 0, mode_q = 0. All strobes 0. out_valid = 0, busy = 0, done = 0, key_sel = 0, subkey_idx = 0.
- IDLE:
  - in_ready = 1.
  - Accept on in_valid & in_ready: latch mode_q, pass_cnt = 0, go to LOAD.
- LOAD (1 cycle):
  - load_block = 1, round_cnt cleared to 0.
  - Next state is ROUND.
- ROUND:
  - round_en = 1 every cycle; round_idx = round_cnt.
  - round_cnt increments each cycle.
  - When round_cnt == NUM_ROUNDS-1: round_cnt rolls over to 0 and next state is PEND.
- PEND (1 cycle):
  - pass_end = 1.
  - If pass_cnt == NUM_PASSES-1, go to OUTV.
  - Otherwise pass_cnt increments and next state is LOAD.
- OUTV:
  - out_valid held high until out_ready is sampled high.
  - On that cycle: done pulses for 1 cycle, next state is IDLE.
  - out_valid deasserts the following cycle.
- Key bank select:
  - Encrypt: key_sel = 0, 1, 2 for passes 0, 1, 2.
  - Decrypt: key_sel = 2, 1, 0 for passes 0, 1, 2.
- Pass direction: forward for encrypt passes 0 and 2 and decrypt pass 1; all other passes reverse.
- Subkey index: forward gives subkey_idx = round_cnt; reverse gives subkey_idx = 15 - round_cnt (4-bit arithmetic).
- key_sel and subkey_idx are valid whenever round_en = 1, and are held at their last value otherwise.
- Latency, with accept at edge T:
  - LOAD at T+1.
  - Pass 0 rounds at T+2..T+17, PEND at T+18.
  - Each pass is 18 cycles.
  - out_valid first high in cycle T+55.
  - Minimum accept-to-accept spacing is 56 cycles with out_ready tied high.
- Abort: from any non-IDLE state, abort = 1 at an edge sends the controller to IDLE. Counters clear, no done, no out_valid. Abort in IDLE is ignored and blocks acceptance that cycle.
- Simultaneous events:
  - n_rst overrides abort, and abort overrides all handshakes.
  - in_valid during a busy state is not accepted (in_ready = 0).
  - Reset mid-operation discards the block.
- Strobe exclusivity: load_block, round_en and pass_end are mutually exclusive, and all are 0 outside LOAD/ROUND/PEND.

Test Plan:
1. Reset then encrypt: in_valid = 1, mode = 0 for one cycle -> load_block at T+1; round_en for 16 cycles with subkey_idx 0..15 and key_sel = 0; the next pass's round_en shows subkey_idx 15..0 with key_sel = 1; out_valid at T+55; done pulses 1 cycle when out_ready = 1.
2. Decrypt (mode = 1) -> key_sel sequence 2, 1, 0; subkey_idx descending in passes 0 and 2 and ascending in pass 1; exactly 48 round_en cycles and 3 pass_end pulses total.
3. Backpressure: out_ready = 0 for 10 cycles after out_valid -> out_valid, busy and in_ready = 0 held stable; in_valid pulses during this window are ignored; done pulses on the cycle out_ready = 1.
4. Abort during pass 1, round 7 -> IDLE next cycle, busy = 0, round_idx = 0, pass_idx = 0, no out_valid/done; a new request is then accepted and completes normally.
5. n_rst = 1 asserted mid-ROUND together with abort -> all outputs at reset values next cycle. Asserting n_rst between edges has no effect until a clk edge (synchronous).
6. Back-to-back blocks, in_valid and out_ready tied high -> accepts exactly every 56 cycles, done count equals accept count, and the strobes are never simultaneously high.
